// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master bus arbiter: bus widths, arbiter
// state encoding, the error read-data pattern and the request bundle used to
// mux a master onto the slave side.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LANE_W = 4;

    // Read data returned to a master whose access timed out.
    localparam logic [DATA_W-1:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // One master's request as seen by the arbiter.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LANE_W-1:0] lane;
        logic              wr;
        logic              valid;
    } bus_req_t;

endpackage

// File: rtl/bus_timeout.sv
// -----------------------------------------------------------------------------
// bus_timeout
// Watchdog counter for a granted bus transaction. The count is cleared while
// `clear` is high and advances by one on every cycle `enable` is high.
// `expired` is high while the count sits at TIMEOUT-1, i.e. during the
// TIMEOUT-th waiting cycle of a grant.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (count -> 0)
//   clear    in   reload the count with zero
//   enable   in   count one waiting cycle
//   expired  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module bus_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            // Holding at LAST keeps the counter from wrapping if the arbiter
            // ever stays granted past expiry.
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one valid/ready slave bus between master 0 (CPU) and master 1
// (DMA/blitter). One master is granted at a time; its request is muxed
// combinationally onto the s_* outputs and the slave's completion pulse and
// read data are returned to it in the same cycle. A watchdog terminates a
// grant that the slave never answers, returning BUS_ERR_DATA and latching a
// sticky error with the address of the first timed-out access.
//
// Parameters:
//   TIMEOUT  waiting cycles allowed before forced termination (>= 2)
//   FAIR     1 = round-robin on ties, 0 = master 0 always wins ties
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m0_*/m1_* addr,wdata,lane,wr   master request fields
//   m0_valid, m1_valid             master request strobes (held until ready)
//   m0_ready, m1_ready             one-cycle completion pulses
//   m0_rdata, m1_rdata             read data, valid with ready
//   s_addr,s_wdata,s_lane,s_wr     forwarded request of the granted master
//   s_valid                        forwarded request strobe
//   s_ready, s_rdata               slave completion pulse and read data
//   err, err_addr                  sticky timeout flag, first timed-out address
//   err_clr                        clears err and err_addr
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter bit FAIR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [LANE_W-1:0] m0_lane,
    input  logic              m0_wr,
    input  logic              m0_valid,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [LANE_W-1:0] m1_lane,
    input  logic              m1_wr,
    input  logic              m1_valid,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [LANE_W-1:0] s_lane,
    output logic              s_wr,
    output logic              s_valid,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr
);

    arb_state_e state;
    logic       last;       // master that completed the most recent grant

    bus_req_t   req0;
    bus_req_t   req1;
    bus_req_t   req_g;      // request of the currently granted master
    logic       granted;
    logic       gnt1;

    logic       expired;
    logic       done;       // slave completed the granted access
    logic       tout;       // watchdog terminates the granted access
    logic       drop;       // granted master withdrew its request
    logic       finish;
    logic       rsp_ready;
    logic       pick1;      // arbitration result in IDLE: grant master 1

    assign req0 = '{addr: m0_addr, wdata: m0_wdata, lane: m0_lane,
                    wr: m0_wr, valid: m0_valid};
    assign req1 = '{addr: m1_addr, wdata: m1_wdata, lane: m1_lane,
                    wr: m1_wr, valid: m1_valid};

    always_comb begin
        req_g   = req0;
        granted = 1'b0;
        gnt1    = 1'b0;
        case (state)
            ST_GNT0: begin
                granted = 1'b1;
            end
            ST_GNT1: begin
                granted = 1'b1;
                gnt1    = 1'b1;
                req_g   = req1;
            end
            default: begin
                granted = 1'b0;
            end
        endcase
    end

    // Slave side: the granted request passes straight through.
    assign s_addr  = req_g.addr;
    assign s_wdata = req_g.wdata;
    assign s_lane  = req_g.lane;
    assign s_wr    = req_g.wr;
    assign s_valid = granted & req_g.valid;

    // s_ready outranks the watchdog when both land in the same cycle.
    assign done   = granted & req_g.valid & s_ready;
    assign tout   = granted & req_g.valid & ~s_ready & expired;
    assign drop   = granted & ~req_g.valid;
    assign finish = done | tout;

    // A transaction aborted by reset never reports completion.
    assign rsp_ready = finish & ~rst;

    assign m0_ready = rsp_ready & ~gnt1;
    assign m1_ready = rsp_ready &  gnt1;

    // The non-granted master simply sees the slave data (don't-care).
    assign m0_rdata = (tout && !gnt1) ? BUS_ERR_DATA : s_rdata;
    assign m1_rdata = (tout &&  gnt1) ? BUS_ERR_DATA : s_rdata;

    // On a tie, round-robin hands the bus to the master not served last.
    assign pick1 = m1_valid & (~m0_valid | (FAIR & ~last));

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .enable  (granted & req_g.valid & ~s_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // s_ready is ignored here; only new requests matter.
                    if (m0_valid || m1_valid) begin
                        state <= pick1 ? ST_GNT1 : ST_GNT0;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    // Every grant ends with at least one IDLE cycle so that
                    // slaves see a fresh rising edge of s_valid per access.
                    if (drop) begin
                        state <= ST_IDLE;
                    end else if (finish) begin
                        state <= ST_IDLE;
                        last  <= gnt1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Clearing wins over a timeout in the same cycle; only the first
            // timed-out address is kept until cleared.
            if (err_clr) begin
                err      <= 1'b0;
                err_addr <= '0;
            end else if (tout) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= req_g.addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Two arbiters (round-robin and fixed priority, TIMEOUT=8) share one set of
// stimulus. A behavioural model per instance tracks who owns the bus, how
// long it has waited and the error flag, and every cycle's outputs are
// compared against it. Directed sequences with literal expectations come
// first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_lane, m1_lane;
    logic        m0_wr, m1_wr, m0_valid, m1_valid;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        err_clr;

    // Index 0: FAIR=1 instance, index 1: FAIR=0 instance.
    logic [1:0]       o_m0_ready, o_m1_ready, o_s_valid, o_s_wr, o_err;
    logic [1:0][31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata, o_err_addr;
    logic [1:0][3:0]  o_s_lane;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TO), .FAIR(1'b1)) u_fair (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lane(m0_lane), .m0_wr(m0_wr),
        .m0_valid(m0_valid), .m0_ready(o_m0_ready[0]), .m0_rdata(o_m0_rdata[0]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lane(m1_lane), .m1_wr(m1_wr),
        .m1_valid(m1_valid), .m1_ready(o_m1_ready[0]), .m1_rdata(o_m1_rdata[0]),
        .s_addr(o_s_addr[0]), .s_wdata(o_s_wdata[0]), .s_lane(o_s_lane[0]),
        .s_wr(o_s_wr[0]), .s_valid(o_s_valid[0]), .s_ready(s_ready), .s_rdata(s_rdata),
        .err(o_err[0]), .err_addr(o_err_addr[0]), .err_clr(err_clr)
    );

    bus_arbiter #(.TIMEOUT(TO), .FAIR(1'b0)) u_fixed (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lane(m0_lane), .m0_wr(m0_wr),
        .m0_valid(m0_valid), .m0_ready(o_m0_ready[1]), .m0_rdata(o_m0_rdata[1]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lane(m1_lane), .m1_wr(m1_wr),
        .m1_valid(m1_valid), .m1_ready(o_m1_ready[1]), .m1_rdata(o_m1_rdata[1]),
        .s_addr(o_s_addr[1]), .s_wdata(o_s_wdata[1]), .s_lane(o_s_lane[1]),
        .s_wr(o_s_wr[1]), .s_valid(o_s_valid[1]), .s_ready(s_ready), .s_rdata(s_rdata),
        .err(o_err[1]), .err_addr(o_err_addr[1]), .err_clr(err_clr)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // own: -1 = nobody holds the bus, else the master index holding it.
    // cnt: cycles the owner has already waited in this grant.
    int          own [2] = '{-1, -1};
    logic        lst [2] = '{1'b1, 1'b1};
    int          cnt [2] = '{0, 0};
    logic        merr[2] = '{1'b0, 1'b0};
    logic [31:0] merr_addr[2] = '{32'h0, 32'h0};

    task automatic model_step(input int d);
        logic        fair;
        logic [1:0]  mv;
        logic [31:0] ga, gw;
        logic [3:0]  gl;
        logic        gwr;
        logic        act, done, tout, drop;
        logic [1:0]  erdy;
        int          x;
        fair = (d == 0);
        mv   = {m1_valid, m0_valid};
        x    = own[d];
        ga   = (x == 1) ? m1_addr  : m0_addr;
        gw   = (x == 1) ? m1_wdata : m0_wdata;
        gl   = (x == 1) ? m1_lane  : m0_lane;
        gwr  = (x == 1) ? m1_wr    : m0_wr;
        act  = 1'b0; done = 1'b0; tout = 1'b0; drop = 1'b0; erdy = 2'b00;
        if (x >= 0) begin
            act  = mv[x[0]];
            drop = !act;
            done = act && s_ready;
            tout = act && !s_ready && (cnt[d] == TO - 1);
            if (!rst && (done || tout)) erdy[x[0]] = 1'b1;
        end

        chk1($sformatf("d%0d s_valid", d), o_s_valid[d], act);
        if (act) begin
            chk32($sformatf("d%0d s_addr", d), o_s_addr[d], ga);
            chk32($sformatf("d%0d s_wdata", d), o_s_wdata[d], gw);
            chk32($sformatf("d%0d s_lane", d), 32'(o_s_lane[d]), 32'(gl));
            chk1($sformatf("d%0d s_wr", d), o_s_wr[d], gwr);
        end
        chk1($sformatf("d%0d m0_ready", d), o_m0_ready[d], erdy[0]);
        chk1($sformatf("d%0d m1_ready", d), o_m1_ready[d], erdy[1]);
        if (erdy[0]) chk32($sformatf("d%0d m0_rdata", d), o_m0_rdata[d], tout ? 32'hFFFF_FFFF : s_rdata);
        if (erdy[1]) chk32($sformatf("d%0d m1_rdata", d), o_m1_rdata[d], tout ? 32'hFFFF_FFFF : s_rdata);
        chk1($sformatf("d%0d err", d), o_err[d], merr[d]);
        chk32($sformatf("d%0d err_addr", d), o_err_addr[d], merr_addr[d]);

        if (rst) begin
            own[d] = -1; lst[d] = 1'b1; cnt[d] = 0; merr[d] = 1'b0; merr_addr[d] = 32'h0;
        end else begin
            if (x < 0) begin
                if (mv == 2'b01)      own[d] = 0;
                else if (mv == 2'b10) own[d] = 1;
                else if (mv == 2'b11) own[d] = fair ? (lst[d] ? 0 : 1) : 0;
                cnt[d] = 0;
            end else if (drop) begin
                own[d] = -1;
            end else if (done || tout) begin
                own[d] = -1;
                lst[d] = (x == 1);
            end else begin
                cnt[d]++;
            end
            if (err_clr) begin
                merr[d] = 1'b0; merr_addr[d] = 32'h0;
            end else if (tout) begin
                if (!merr[d]) merr_addr[d] = ga;
                merr[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        logic r0, r1;
        rst = 1'b1; err_clr = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        m0_addr = 0; m0_wdata = 0; m0_lane = 0; m0_wr = 0; m0_valid = 0;
        m1_addr = 0; m1_wdata = 0; m1_lane = 0; m1_wr = 0; m1_valid = 0;
        tick(); tick();
        #1;
        chk1("reset s_valid", o_s_valid[0], 1'b0);
        chk1("reset m0_ready", o_m0_ready[0], 1'b0);
        chk1("reset err", o_err[0], 1'b0);
        chk32("reset err_addr", o_err_addr[0], 32'h0);
        rst = 1'b0;

        // Single read with a 3-cycle slave wait.
        tick();
        m0_addr = 32'h0000_0010; m0_wr = 1'b0; m0_lane = 4'hF; m0_valid = 1'b1;
        tick(); #1;
        chk1("read s_valid", o_s_valid[0], 1'b1);
        chk32("read s_addr", o_s_addr[0], 32'h0000_0010);
        tick(); tick();
        tick(); s_ready = 1'b1; s_rdata = 32'h1234_5678; #1;
        chk1("read m0_ready", o_m0_ready[0], 1'b1);
        chk32("read m0_rdata", o_m0_rdata[0], 32'h1234_5678);
        tick(); s_ready = 1'b0; m0_valid = 1'b0; #1;
        chk1("read gap s_valid", o_s_valid[0], 1'b0);
        chk1("read gap m0_ready", o_m0_ready[0], 1'b0);

        // Contention: both write continuously.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        tick();
        m0_addr = 32'h100; m0_wdata = 32'hA0; m0_lane = 4'h3; m0_wr = 1'b1; m0_valid = 1'b1;
        m1_addr = 32'h200; m1_wdata = 32'hB0; m1_lane = 4'hC; m1_wr = 1'b1; m1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick(); #1;
            chk1("contention s_valid", o_s_valid[0], 1'b1);
            chk32("contention grant", o_s_addr[0], (g % 2 == 0) ? m0_addr : m1_addr);
            chk32("contention wdata", o_s_wdata[0], (g % 2 == 0) ? m0_wdata : m1_wdata);
            chk32("contention lane", 32'(o_s_lane[0]), (g % 2 == 0) ? 32'h3 : 32'hC);
            chk32("fixed grant", o_s_addr[1], m0_addr);
            s_ready = 1'b1; s_rdata = 32'h0;
            tick();
            s_ready = 1'b0;
            if (g % 2 == 0) begin m0_addr += 4; m0_wdata += 1; end
            else begin m1_addr += 4; m1_wdata += 1; end
            if (g == 3) m0_valid = 1'b0;
            #1;
            chk1("contention gap", o_s_valid[0], 1'b0);
            chk1("fixed gap", o_s_valid[1], 1'b0);
        end
        tick(); #1;
        chk1("fixed m1 s_valid", o_s_valid[1], 1'b1);
        chk32("fixed m1 grant", o_s_addr[1], m1_addr);
        s_ready = 1'b1;
        tick(); s_ready = 1'b0; m1_valid = 1'b0;

        // Timeout on a master 1 read.
        tick();
        m1_addr = 32'h1700_0000; m1_wr = 1'b0; m1_valid = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); #1;
            if (o_m1_ready[0]) begin lat = k; break; end
        end
        chk32("timeout latency", 32'(lat), 32'd8);
        chk32("timeout rdata", o_m1_rdata[0], 32'hFFFF_FFFF);
        tick(); m1_valid = 1'b0; #1;
        chk1("timeout err", o_err[0], 1'b1);
        chk32("timeout err_addr", o_err_addr[0], 32'h1700_0000);

        // Second timeout keeps the first address.
        tick();
        m0_addr = 32'h0000_2000; m0_wr = 1'b1; m0_valid = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); #1;
            if (o_m0_ready[0]) begin lat = k; break; end
        end
        chk32("timeout2 latency", 32'(lat), 32'd8);
        tick(); m0_valid = 1'b0; #1;
        chk1("timeout2 err", o_err[0], 1'b1);
        chk32("timeout2 err_addr", o_err_addr[0], 32'h1700_0000);

        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0; #1;
        chk1("clear err", o_err[0], 1'b0);
        chk32("clear err_addr", o_err_addr[0], 32'h0);

        // s_ready in the expiry cycle.
        tick();
        m0_addr = 32'h0000_3000; m0_wr = 1'b0; m0_valid = 1'b1;
        repeat (7) tick();
        tick(); s_ready = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
        chk1("collision m0_ready", o_m0_ready[0], 1'b1);
        chk32("collision rdata", o_m0_rdata[0], 32'hCAFE_F00D);
        tick(); s_ready = 1'b0; m0_valid = 1'b0; #1;
        chk1("collision err", o_err[0], 1'b0);

        // Reset during a master 1 grant.
        tick();
        m1_addr = 32'h0000_4000; m1_valid = 1'b1;
        tick(); #1;
        chk1("rstmid granted", o_s_valid[0], 1'b1);
        tick(); rst = 1'b1; s_ready = 1'b1; #1;
        chk1("rstmid no ready", o_m1_ready[0], 1'b0);
        tick(); rst = 1'b0; s_ready = 1'b0;
        m0_addr = 32'h0000_5000; m0_valid = 1'b1; #1;
        chk1("rstmid s_valid", o_s_valid[0], 1'b0);
        chk1("rstmid m1_ready", o_m1_ready[0], 1'b0);
        chk1("rstmid err", o_err[0], 1'b0);
        tick(); #1;
        chk1("rstmid tie valid", o_s_valid[0], 1'b1);
        chk32("rstmid tie grant", o_s_addr[0], 32'h0000_5000);
        s_ready = 1'b1;
        tick(); s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;

        // Randomized traffic; masters occasionally withdraw requests.
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst     = ($urandom_range(0, 199) == 0);
            err_clr = ($urandom_range(0, 49) == 0);
            s_ready = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
            if (!m0_valid || r0 || $urandom_range(0, 31) == 0) begin
                m0_valid = ($urandom_range(0, 2) != 0);
                m0_addr = $urandom; m0_wdata = $urandom;
                m0_lane = 4'($urandom); m0_wr = 1'($urandom);
            end
            if (!m1_valid || r1 || $urandom_range(0, 31) == 0) begin
                m1_valid = ($urandom_range(0, 2) != 0);
                m1_addr = $urandom; m1_wdata = $urandom;
                m1_lane = 4'($urandom); m1_wr = 1'($urandom);
            end
            #1;
            r0 = o_m0_ready[0];
            r1 = o_m1_ready[0];
        end
        tick();
        rst = 1'b0; err_clr = 1'b0; s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
